// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, 1-cycle-read memory between the
// fetch path (read-only) and the load/store path (read/write).
// Data has priority on conflicts. Once fetch has lost MAX_FETCH_WAIT
// consecutive conflicts, it is forced to win.
// Ports:
//   clk, resetN                       clock and asynchronous active-low reset
//   fetchReq/fetchAddr/fetchGnt       fetch request handshake
//   fetchRvalid/fetchRdata            fetch read response, one cycle after grant
//   dataReq/dataWrite/dataAddr/
//   dataWdata/dataGnt                 load/store request handshake
//   dataRvalid/dataRdata              data read response, one cycle after grant
//   memAddr/memWrite/memDin/memDout   memory port
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MAX_FETCH_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  fetchReq,
    input  logic [ADDR_WIDTH-1:0] fetchAddr,
    output logic                  fetchGnt,
    output logic                  fetchRvalid,
    output logic [DATA_WIDTH-1:0] fetchRdata,
    input  logic                  dataReq,
    input  logic                  dataWrite,
    input  logic [ADDR_WIDTH-1:0] dataAddr,
    input  logic [DATA_WIDTH-1:0] dataWdata,
    output logic                  dataGnt,
    output logic                  dataRvalid,
    output logic [DATA_WIDTH-1:0] dataRdata,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic                  memWrite,
    output logic [DATA_WIDTH-1:0] memDin,
    input  logic [DATA_WIDTH-1:0] memDout
);

    localparam int unsigned CNT_W = (MAX_FETCH_WAIT == 0) ? 1 : $clog2(MAX_FETCH_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_FETCH_WAIT);

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_e;

    owner_e           rd_owner;
    owner_e           rd_owner_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_nxt;
    logic             fetch_win;

    // State registers: owner of the read in flight and the fetch starvation count.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rd_owner <= OWN_NONE;
            wait_cnt <= '0;
        end else begin
            rd_owner <= rd_owner_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Arbitration, next-state and memory drive.
    // The counter saturates at CNT_MAX, so equality is enough to detect starvation.
    // With MAX_FETCH_WAIT=0 the counter stays at 0, so fetch always wins.
    always_comb begin
        fetch_win    = 1'b0;
        fetchGnt     = 1'b0;
        dataGnt      = 1'b0;
        rd_owner_nxt = OWN_NONE;
        wait_cnt_nxt = '0;
        memAddr      = '0;
        memWrite     = 1'b0;
        memDin       = '0;

        fetch_win = (wait_cnt == CNT_MAX);
        fetchGnt  = resetN & fetchReq & (~dataReq | fetch_win);
        dataGnt   = resetN & dataReq & ~(fetchReq & fetch_win);

        if (fetchGnt) begin
            rd_owner_nxt = OWN_FETCH;
            memAddr      = fetchAddr;
        end else if (dataGnt) begin
            rd_owner_nxt = dataWrite ? OWN_NONE : OWN_DATA;
            memAddr      = dataAddr;
            memWrite     = dataWrite;
            memDin       = dataWdata;
        end

        if (fetchReq && !fetchGnt) begin
            wait_cnt_nxt = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + CNT_W'(1);
        end
    end

    // Route the memory output to whichever requester owns this cycle's read.
    always_comb begin
        fetchRvalid = (rd_owner == OWN_FETCH);
        dataRvalid  = (rd_owner == OWN_DATA);
        fetchRdata  = fetchRvalid ? memDout : '0;
        dataRdata   = dataRvalid ? memDout : '0;
    end

endmodule
